// File: rtl/snake_engine.sv
// snake_engine: 15x15 snake game engine with a ring-buffer body, LFSR apple placement and an occupancy map.
// Defining SNAKE_WRAP_EN makes the head wrap at the grid edges instead of colliding with the wall.
module snake_engine #(
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int MAX_LEN = 225
) (
  input  logic         mastClk,
  input  logic         rst,
  input  logic         tick,
  input  logic         up,
  input  logic         down,
  input  logic         left,
  input  logic         right,
  input  logic         start,
  output logic [3:0]   Head_X,
  output logic [3:0]   Head_Y,
  output logic [3:0]   Tail_X,
  output logic [3:0]   Tail_Y,
  output logic [3:0]   Apple_X,
  output logic [3:0]   Apple_Y,
  output logic [224:0] Cell_Snake_Vector,
  output logic [7:0]   score,
  output logic         game_over,
  output logic         win
);
  localparam int PW = $clog2(MAX_LEN);
  localparam logic [224:0] INIT_VEC = (225'd1 << 37) | (225'd1 << 52) | (225'd1 << 67);
  localparam logic [1:0] D_R = 2'd0, D_L = 2'd1, D_U = 2'd2, D_D = 2'd3;
  typedef enum logic [1:0] {IDLE, RUN, PLACE, OVER} state_t;
  state_t state_q, state_d;
  logic [1:0] dir_q, dir_d, pend_q, pend_d, req;
  logic [3:0] hx_q, hx_d, hy_q, hy_d, tx_q, tx_d, ty_q, ty_d, ax_q, ax_d, ay_q, ay_d, nx, ny;
  logic [7:0] score_q, score_d, len_q, len_d, cand_q, cand_d, lfsr_q, lfsr_d, nidx, tidx;
  logic [PW-1:0] hp_q, hp_d, tp_q, tp_d, hp_n, tp_n;
  logic [224:0] vec_q, vec_d;
  logic [7:0] seg_q [MAX_LEN];
  logic go_q, go_d, win_q, win_d, wall, eat, hit, init, seg_we;
  assign {Head_X, Head_Y, Tail_X, Tail_Y, Apple_X, Apple_Y} = {hx_q, hy_q, tx_q, ty_q, ax_q, ay_q};
  assign Cell_Snake_Vector = vec_q;
  assign score = score_q;
  assign game_over = go_q;
  assign win = win_q;
  always_comb begin
    req = up ? D_U : down ? D_D : left ? D_L : D_R;
    hp_n = (hp_q == PW'(MAX_LEN - 1)) ? '0 : hp_q + 1'b1;
    tp_n = (tp_q == PW'(MAX_LEN - 1)) ? '0 : tp_q + 1'b1;
`ifdef SNAKE_WRAP_EN
    nx = pend_q == D_R ? (hx_q == 4'd14 ? 4'd0 : hx_q + 4'd1) :
         pend_q == D_L ? (hx_q == 4'd0 ? 4'd14 : hx_q - 4'd1) : hx_q;
    ny = pend_q == D_D ? (hy_q == 4'd14 ? 4'd0 : hy_q + 4'd1) :
         pend_q == D_U ? (hy_q == 4'd0 ? 4'd14 : hy_q - 4'd1) : hy_q;
    wall = 1'b0;
`else
    nx = pend_q == D_R ? hx_q + 4'd1 : pend_q == D_L ? hx_q - 4'd1 : hx_q;
    ny = pend_q == D_D ? hy_q + 4'd1 : pend_q == D_U ? hy_q - 4'd1 : hy_q;
    // stepping off either edge of 0..14 lands on 15 in four bits
    wall = (nx == 4'hF) || (ny == 4'hF);
`endif
    nidx = {4'd0, nx} * 8'd15 + {4'd0, ny};
    tidx = {4'd0, tx_q} * 8'd15 + {4'd0, ty_q};
    eat = (nx == ax_q) && (ny == ay_q);
    hit = wall || (vec_q[nidx] && !(nidx == tidx && !eat));
    state_d = state_q;
    dir_d = dir_q;
    hx_d = hx_q;
    hy_d = hy_q;
    tx_d = tx_q;
    ty_d = ty_q;
    ax_d = ax_q;
    ay_d = ay_q;
    score_d = score_q;
    len_d = len_q;
    cand_d = cand_q;
    hp_d = hp_q;
    tp_d = tp_q;
    vec_d = vec_q;
    go_d = go_q;
    win_d = win_q;
    init = 1'b0;
    seg_we = 1'b0;
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    // a pulse is judged against the move that will have executed by this edge
    pend_d = ((up || down || left || right) &&
              req != (((tick && state_q == RUN) ? pend_q : dir_q) ^ 2'b01)) ? req : pend_q;
    if (state_q == IDLE) begin
      if (start) state_d = RUN;
    end else if (state_q == OVER) begin
      init = start;
    end else if (state_q == PLACE) begin
      if (!vec_q[cand_q]) begin
        ax_d = 4'(cand_q / 8'd15);
        ay_d = 4'(cand_q % 8'd15);
        state_d = RUN;
      end else cand_d = (cand_q == 8'd224) ? 8'd0 : cand_q + 8'd1;
    end else if (tick) begin
      if (hit) begin
        state_d = OVER;
        go_d = 1'b1;
      end else begin
        seg_we = 1'b1;
        hp_d = hp_n;
        hx_d = nx;
        hy_d = ny;
        dir_d = pend_q;
        if (eat) begin
          score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          len_d = len_q + 8'd1;
          ax_d = 4'hF;
          ay_d = 4'hF;
          state_d = (len_q == 8'(MAX_LEN - 1)) ? OVER : PLACE;
          go_d = (len_q == 8'(MAX_LEN - 1));
          win_d = (len_q == 8'(MAX_LEN - 1));
          cand_d = (lfsr_q >= 8'd225) ? lfsr_q - 8'd225 : lfsr_q;
        end else begin
          vec_d[tidx] = 1'b0;
          tp_d = tp_n;
          {tx_d, ty_d} = seg_q[tp_n];
        end
        vec_d[nidx] = 1'b1;
      end
    end
    if (init) begin
      state_d = IDLE;
      {dir_d, pend_d} = {D_R, D_R};
      {hx_d, hy_d, tx_d, ty_d, ax_d, ay_d} = {4'd4, 4'd7, 4'd2, 4'd7, 4'd10, 4'd7};
      {score_d, len_d, cand_d} = {8'd0, 8'd3, 8'd0};
      {hp_d, tp_d} = {PW'(2), PW'(0)};
      vec_d = INIT_VEC;
      {go_d, win_d} = 2'b00;
    end
  end
  always_ff @(posedge mastClk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      {dir_q, pend_q} <= {D_R, D_R};
      {hx_q, hy_q, tx_q, ty_q, ax_q, ay_q} <= {4'd4, 4'd7, 4'd2, 4'd7, 4'd10, 4'd7};
      {score_q, len_q, cand_q} <= {8'd0, 8'd3, 8'd0};
      {hp_q, tp_q} <= {PW'(2), PW'(0)};
      vec_q <= INIT_VEC;
      {go_q, win_q} <= 2'b00;
      lfsr_q <= LFSR_SEED;
      for (int i = 0; i < MAX_LEN; i++) seg_q[i] <= 8'h00;
      {seg_q[0], seg_q[1], seg_q[2]} <= {8'h27, 8'h37, 8'h47};
    end else begin
      state_q <= state_d;
      {dir_q, pend_q} <= {dir_d, pend_d};
      {hx_q, hy_q, tx_q, ty_q, ax_q, ay_q} <= {hx_d, hy_d, tx_d, ty_d, ax_d, ay_d};
      {score_q, len_q, cand_q} <= {score_d, len_d, cand_d};
      {hp_q, tp_q} <= {hp_d, tp_d};
      vec_q <= vec_d;
      {go_q, win_q} <= {go_d, win_d};
      lfsr_q <= lfsr_d;
      if (init) {seg_q[0], seg_q[1], seg_q[2]} <= {8'h27, 8'h37, 8'h47};
      else if (seg_we) seg_q[hp_n] <= {nx, ny};
    end
  end
endmodule
